// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: reads back a 3-input combinational gate.
// It steps {in1,in2,in3} through vectors 000..111 and holds each vector for
// SETTLE_CYCLES+1 cycles. It samples the gate output on the last edge of
// each window and builds code, where bit[7-v] is the output for vector v.
// It then compares code against the reference value latched at start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request a sweep (accepted in IDLE or DONE)
//   expected     reference code, latched when start is accepted
//   in1..in3     gate inputs; in1 is the vector MSB
//   out          gate output under test
//   busy, done   sweep in progress / result valid
//   code, match  captured truth table / code equals latched reference
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       match
);

  // Settle counter is at least 8 bits wide, so it covers 0..255 and up.
  localparam int unsigned CNT_W = ($clog2(SETTLE_CYCLES + 1) > 8) ?
                                  $clog2(SETTLE_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       exp_q, exp_d;
  logic [2:0]       in_q, in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             match_q, match_d;

  // Next-state logic, plus output values computed from the next state.
  // Every output is registered and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    exp_d   = exp_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          exp_d   = expected;
          code_d  = 8'h00;
          vec_d   = 3'd0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // Last edge of the window: capture the output for this vector.
          code_d[3'd7 - vec_q] = out;
          cnt_d                = '0;
          if (vec_q == 3'd7) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
    in_d    = busy_d ? vec_d : 3'b000;
    match_d = done_d && (code_d == exp_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      code_q  <= 8'h00;
      exp_q   <= 8'h00;
      in_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      exp_q   <= exp_d;
      in_q    <= in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign in1   = in_q[2];
  assign in2   = in_q[1];
  assign in3   = in_q[0];
  assign busy  = busy_q;
  assign done  = done_q;
  assign code  = code_q;
  assign match = match_q;

endmodule
